// File: rtl/oscillator.sv
// oscillator: single-voice audio oscillator running on the sample clock.
// A 32-bit phase accumulator is advanced by an increment derived from a
// 1/32 Hz frequency word plus a small upward detune. The pre-update phase
// is mapped to a sine, square, sawtooth or triangle sample, then registered.
//
// Ports:
//   clk     in   1   sample clock (48 kHz), all state on rising edge
//   reset   in   1   asynchronous active-low; clears phase and wave
//   freq    in  20   unsigned frequency, 1/32 Hz units (14080 = 440 Hz)
//   ctrl    in   2   00 sine, 01 square, 10 sawtooth, 11 triangle
//   detune  in   4   upward offset in steps of freq/256
//   wave    out 16   signed sample, registered
module oscillator (
    input  logic               clk,
    input  logic               reset,
    input  logic [19:0]        freq,
    input  logic [1:0]         ctrl,
    input  logic [3:0]         detune,
    output logic signed [15:0] wave
);

    localparam int unsigned FREQ_W  = 20;
    localparam int unsigned PROD_W  = 24;
    localparam int unsigned FEFF_W  = 21;
    localparam int unsigned PHASE_W = 32;
    localparam int unsigned SMP_W   = 16;
    localparam int unsigned ROM_AW  = 6;
    localparam int unsigned ROM_DW  = 15;

    // 2^32 / (48000 * 32), rounded: phase step per 1/32 Hz at 48 kHz
    localparam logic [PHASE_W-1:0] INC_K = PHASE_W'(2796);

    localparam logic signed [SMP_W-1:0] SQ_HI = 16'sh7FFF;
    localparam logic signed [SMP_W-1:0] SQ_LO = 16'sh8001;

    logic [PHASE_W-1:0]       r_phase;
    logic [FREQ_W-5:0]        w_fd_hi;
    logic [FEFF_W-1:0]        w_feff;
    logic [PHASE_W-1:0]       w_inc;
    logic [ROM_AW-1:0]        w_rom_idx;
    logic [ROM_DW-1:0]        w_rom_val;
    logic signed [SMP_W-1:0]  w_rom_ext;
    logic                     w_sine_zero;
    logic signed [SMP_W-1:0]  w_sine;
    logic signed [SMP_W-1:0]  w_square;
    logic signed [SMP_W-1:0]  w_saw;
    logic [ROM_DW-1:0]        w_tri_t;
    logic signed [SMP_W-1:0]  w_tri;
    logic signed [SMP_W-1:0]  w_next_wave;

    // Detuned frequency: freq + (freq*detune)>>8; 21 bits never overflows
    assign w_fd_hi = 16'((PROD_W'(freq) * PROD_W'(detune)) >> 8);
    assign w_feff  = FEFF_W'(freq) + FEFF_W'(w_fd_hi);

    // Worst case ~3.1e9 fits in 32 bits
    assign w_inc = PHASE_W'(w_feff) * INC_K;

    // Phase accumulator, wraps by natural binary overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + w_inc;
        end
    end

    // Quarter-wave index: second and fourth quarters read the table mirrored
    assign w_rom_idx = r_phase[30] ? ~r_phase[29:24] : r_phase[29:24];

    // Quarter-wave table, entry k = round(32767*sin(pi/2*(k+0.5)/64))
    always_comb begin
        w_rom_val = '0;
        case (w_rom_idx)
            6'd0:  w_rom_val = 15'd402;   6'd1:  w_rom_val = 15'd1206;
            6'd2:  w_rom_val = 15'd2009;  6'd3:  w_rom_val = 15'd2811;
            6'd4:  w_rom_val = 15'd3612;  6'd5:  w_rom_val = 15'd4410;
            6'd6:  w_rom_val = 15'd5205;  6'd7:  w_rom_val = 15'd5998;
            6'd8:  w_rom_val = 15'd6786;  6'd9:  w_rom_val = 15'd7571;
            6'd10: w_rom_val = 15'd8351;  6'd11: w_rom_val = 15'd9126;
            6'd12: w_rom_val = 15'd9896;  6'd13: w_rom_val = 15'd10659;
            6'd14: w_rom_val = 15'd11417; 6'd15: w_rom_val = 15'd12167;
            6'd16: w_rom_val = 15'd12910; 6'd17: w_rom_val = 15'd13645;
            6'd18: w_rom_val = 15'd14372; 6'd19: w_rom_val = 15'd15090;
            6'd20: w_rom_val = 15'd15800; 6'd21: w_rom_val = 15'd16499;
            6'd22: w_rom_val = 15'd17189; 6'd23: w_rom_val = 15'd17869;
            6'd24: w_rom_val = 15'd18537; 6'd25: w_rom_val = 15'd19195;
            6'd26: w_rom_val = 15'd19841; 6'd27: w_rom_val = 15'd20475;
            6'd28: w_rom_val = 15'd21096; 6'd29: w_rom_val = 15'd21705;
            6'd30: w_rom_val = 15'd22301; 6'd31: w_rom_val = 15'd22884;
            6'd32: w_rom_val = 15'd23452; 6'd33: w_rom_val = 15'd24007;
            6'd34: w_rom_val = 15'd24547; 6'd35: w_rom_val = 15'd25072;
            6'd36: w_rom_val = 15'd25582; 6'd37: w_rom_val = 15'd26077;
            6'd38: w_rom_val = 15'd26556; 6'd39: w_rom_val = 15'd27019;
            6'd40: w_rom_val = 15'd27466; 6'd41: w_rom_val = 15'd27896;
            6'd42: w_rom_val = 15'd28310; 6'd43: w_rom_val = 15'd28706;
            6'd44: w_rom_val = 15'd29085; 6'd45: w_rom_val = 15'd29447;
            6'd46: w_rom_val = 15'd29791; 6'd47: w_rom_val = 15'd30117;
            6'd48: w_rom_val = 15'd30424; 6'd49: w_rom_val = 15'd30714;
            6'd50: w_rom_val = 15'd30985; 6'd51: w_rom_val = 15'd31237;
            6'd52: w_rom_val = 15'd31470; 6'd53: w_rom_val = 15'd31685;
            6'd54: w_rom_val = 15'd31880; 6'd55: w_rom_val = 15'd32057;
            6'd56: w_rom_val = 15'd32213; 6'd57: w_rom_val = 15'd32351;
            6'd58: w_rom_val = 15'd32469; 6'd59: w_rom_val = 15'd32567;
            6'd60: w_rom_val = 15'd32646; 6'd61: w_rom_val = 15'd32705;
            6'd62: w_rom_val = 15'd32745; 6'd63: w_rom_val = 15'd32765;
            default: w_rom_val = '0;
        endcase
    end

    // Half-sample-offset table never yields 0, so force the zero crossings
    assign w_sine_zero = (r_phase[30:24] == 7'd0);
    assign w_rom_ext   = $signed({1'b0, w_rom_val});
    assign w_sine      = w_sine_zero ? '0 :
                         (r_phase[31] ? -w_rom_ext : w_rom_ext);

    assign w_square = r_phase[31] ? SQ_LO : SQ_HI;

    // Offset-binary to two's complement by inverting the MSB
    assign w_saw = $signed({~r_phase[31], r_phase[30:16]});

    // Fold the second half back down, then double and re-centre
    assign w_tri_t = r_phase[31] ? ~r_phase[30:16] : r_phase[30:16];
    assign w_tri   = $signed({~w_tri_t[14], w_tri_t[13:0], 1'b0});

    // Waveform select from the pre-update phase
    always_comb begin
        w_next_wave = '0;
        unique case (ctrl)
            2'b00: w_next_wave = w_sine;
            2'b01: w_next_wave = w_square;
            2'b10: w_next_wave = w_saw;
            2'b11: w_next_wave = w_tri;
            default: w_next_wave = '0;
        endcase
    end

    // Output sample register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wave <= '0;
        end else begin
            wave <= w_next_wave;
        end
    end

endmodule

// File: tb/tb_oscillator.sv
// tb_oscillator: directed bench for oscillator. A behavioural phase model
// predicts every sample; hand-computed values pin down key points.
module tb_oscillator;

    logic               clk = 1'b0;
    logic               reset;
    logic [19:0]        freq;
    logic [1:0]         ctrl;
    logic [3:0]         detune;
    logic signed [15:0] wave;

    oscillator dut (
        .clk    (clk),
        .reset  (reset),
        .freq   (freq),
        .ctrl   (ctrl),
        .detune (detune),
        .wave   (wave)
    );

    always #5 clk = ~clk;

    int          n_vec   = 0;
    int          n_err   = 0;
    logic [31:0] m_phase = 32'd0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_inc(input int unsigned f, input int unsigned d);
        longint feff;
        longint prod;
        feff = longint'(f) + (longint'(f) * longint'(d)) / 256;
        prod = feff * 2796;
        return prod[31:0];
    endfunction

    function automatic int m_wave(input logic [1:0] c, input logic [31:0] p);
        int u;
        int k;
        int v;
        real ang;
        u = int'(p >> 16);
        case (c)
            2'b00: begin
                if (p[31:24] == 8'h00 || p[31:24] == 8'h80) return 0;
                k   = p[30] ? 63 - int'(p[29:24]) : int'(p[29:24]);
                ang = 3.14159265358979 * (real'(k) + 0.5) / 128.0;
                v   = $rtoi(32767.0 * $sin(ang) + 0.5);
                return p[31] ? -v : v;
            end
            2'b01:   return p[31] ? -32767 : 32767;
            2'b10:   return u - 32768;
            default: return (u < 32768) ? 2 * u - 32768 : 2 * (65535 - u) - 32768;
        endcase
    endfunction

    // One clock edge: predict from current model phase, then advance it
    task automatic tick(input string tag);
        int exp;
        @(posedge clk);
        exp     = m_wave(ctrl, m_phase);
        m_phase = m_phase + m_inc(freq, detune);
        #1;
        check_val(tag, int'(wave), exp);
    endtask

    // Asynchronous reset pulse launched while clk is high
    task automatic apply_reset();
        #2 reset = 1'b0;
        #1 check_val("rst_async", int'(wave), 0);
        @(posedge clk);
        #1 check_val("rst_hold", int'(wave), 0);
        @(negedge clk);
        reset   = 1'b1;
        m_phase = 32'd0;
    endtask

    // Run n edges, tracking square rises, downward steps and odd saw steps
    task automatic run(input int n, input string tag, output int rises,
                       output int drops, output int bad_steps);
        int prev;
        int cur;
        rises = 0; drops = 0; bad_steps = 0;
        prev  = int'(wave);
        for (int i = 0; i < n; i++) begin
            tick(tag);
            cur = int'(wave);
            if (prev < 0 && cur > 0) rises++;
            if (cur < prev) drops++;
            else if (cur - prev != 600 && cur - prev != 601) bad_steps++;
            prev = cur;
        end
    endtask

    int rises, drops, bad;

    initial begin
        reset = 1'b1; freq = 20'd0; ctrl = 2'b00; detune = 4'd0;
        #1;
        apply_reset();

        // Frozen phase with freq=0: sine stays at 0
        for (int i = 0; i < 5; i++) tick("frozen");
        check_val("frozen_dir", int'(wave), 0);

        // 440 Hz square over one second of samples
        apply_reset();
        ctrl = 2'b01; freq = 20'd14080; detune = 4'd0;
        tick("sq440");
        check_val("sq_first", int'(wave), 32767);
        run(47999, "sq440", rises, drops, bad);
        check_val("sq440_rises", rises, 439);

        // Sawtooth: increment 39367680 -> 600.7 LSB per edge
        apply_reset();
        ctrl = 2'b10;
        tick("saw"); check_val("saw_p0", int'(wave), -32768);
        tick("saw"); check_val("saw_p1", int'(wave), -32168);
        tick("saw"); check_val("saw_p2", int'(wave), -31567);
        run(200, "saw", rises, drops, bad);
        check_val("saw_wraps", drops, 1);
        check_val("saw_steps", bad, 0);

        // Detune 5: feff 14355, inc 40136580
        apply_reset();
        detune = 4'd5;
        tick("det5"); tick("det5");
        check_val("det5_saw", int'(wave), -32156);
        apply_reset();
        ctrl = 2'b01;
        tick("det5sq");
        run(11999, "det5sq", rises, drops, bad);
        check_val("det5_rises", rises, 112);

        // Detune 15: feff 14905, inc 41674380
        apply_reset();
        ctrl = 2'b10; detune = 4'd15;
        tick("det15"); tick("det15");
        check_val("det15_saw", int'(wave), -32133);

        // Triangle
        apply_reset();
        ctrl = 2'b11; detune = 4'd0;
        tick("tri"); check_val("tri_p0", int'(wave), -32768);
        tick("tri"); check_val("tri_p1", int'(wave), -31568);
        for (int i = 0; i < 300; i++) tick("tri");

        // Sine, including a full period past both quarter boundaries
        apply_reset();
        ctrl = 2'b00;
        tick("sine"); check_val("sine_p0", int'(wave), 0);
        for (int i = 0; i < 300; i++) tick("sine");

        // Largest increment: freq all ones, detune 15 -> inc 3103599144
        apply_reset();
        freq = 20'hFFFFF; detune = 4'd15;
        tick("max"); tick("max");
        check_val("max_sine", int'(wave), -32213);
        apply_reset();
        ctrl = 2'b10;
        tick("max"); tick("max");
        check_val("max_saw", int'(wave), 14589);
        for (int i = 0; i < 50; i++) tick("max");

        // Mode and detune switching without reset: phase stays continuous
        apply_reset();
        freq = 20'd14080; detune = 4'd3;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                ctrl = 2'(c);
                for (int i = 0; i < 60; i++) tick("switch");
            end
            detune = 4'd11;
        end
        for (int i = 0; i < 20; i++) begin
            freq = 20'(1000 + 3000 * i);
            tick("fsweep");
        end

        // Reset mid-run, then resume from phase 0
        ctrl = 2'b01;
        tick("pre_rst");
        apply_reset();
        tick("post_rst");
        check_val("post_rst_sq", int'(wave), 32767);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
